// File: rtl/hdc_float_pkg.sv
// Shared floating-point definitions for the hypervector bundling path.
// Field widths, accumulator FSM encoding and common constants.
package hdc_float_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned GUARD_W = 3;
    localparam int unsigned ELEM_W  = EXP_W + MANT_W + 1;

    typedef logic [2:0] acc_state_t;

    localparam acc_state_t S_IDLE  = 3'd0;
    localparam acc_state_t S_ALIGN = 3'd1;
    localparam acc_state_t S_ADD   = 3'd2;
    localparam acc_state_t S_NORM  = 3'd3;
    localparam acc_state_t S_EMIT  = 3'd4;

    localparam logic [ELEM_W-1:0] FP_ZERO = '0;

    function automatic logic [ELEM_W-1:0] max_finite(input logic sign);
        return {sign, {(EXP_W - 1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
    endfunction

endpackage

// File: rtl/leading_zero_count.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module leading_zero_count
    import hdc_float_pkg::*;
#(
    parameter int unsigned WIDTH       = MANT_W + 1 + GUARD_W,
    parameter int unsigned COUNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]       value,
    output logic [COUNT_WIDTH-1:0] count
);

    logic found;

    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[i]) begin
                    found = 1'b1;
                end else begin
                    count = count + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/element_accumulate_f.sv
// Multi-cycle floating-point bundle accumulator: four-stage add per element,
// emits the truncated running sum for one cycle when the last element lands.
module element_accumulate_f
    import hdc_float_pkg::*;
#(
    parameter int unsigned EXPONENT_WIDTH = EXP_W,
    parameter int unsigned MANTISSA_WIDTH = MANT_W
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_last,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] elem_in,
    output logic                                   out_valid,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] elem_out
);

    localparam int unsigned W     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam int unsigned SIG_W = MANTISSA_WIDTH + 1 + GUARD_W;
    localparam int unsigned CNT_W = $clog2(SIG_W + 1);
    localparam int unsigned XE_W  = EXPONENT_WIDTH + 2;
    localparam logic [EXPONENT_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [XE_W-1:0]           EXP_SAT  = {2'b00, EXP_ONES};

    acc_state_t state_q, state_d;

    logic [W-1:0]              op_q, acc_q, elem_out_q;
    logic                      last_q;
    logic                      big_sign_q, eff_sub_q;
    logic [EXPONENT_WIDTH-1:0] big_exp_q;
    logic [SIG_W-1:0]          big_sig_q, small_sig_q;
    logic [SIG_W:0]            sum_q, sum_d;

    function automatic logic [W-1:0] sat_value(input logic sign);
        return {sign, {(EXPONENT_WIDTH - 1){1'b1}}, 1'b0, {MANTISSA_WIDTH{1'b1}}};
    endfunction

    function automatic logic [SIG_W-1:0] significand(input logic [W-1:0] v);
        return {|v[W-2:MANTISSA_WIDTH], v[MANTISSA_WIDTH-1:0], {GUARD_W{1'b0}}};
    endfunction

    // Denormals flush to +0, inf/NaN clamp to max finite before entering the datapath.
    logic [EXPONENT_WIDTH-1:0] in_exp;
    logic [W-1:0]              op_clean;

    assign in_exp = elem_in[W-2:MANTISSA_WIDTH];

    always_comb begin
        op_clean = elem_in;
        if (in_exp == '0) begin
            op_clean = '0;
        end else if (&in_exp) begin
            op_clean = sat_value(elem_in[W-1]);
        end
    end

    // Ordering on {exp, mant} is magnitude ordering, so the big operand never goes negative.
    logic                      op_is_big;
    logic [W-1:0]              big_val, small_val;
    logic [EXPONENT_WIDTH-1:0] exp_diff;
    logic [SIG_W-1:0]          small_aligned;

    always_comb begin
        op_is_big = op_q[W-2:0] > acc_q[W-2:0];
        big_val   = op_is_big ? op_q : acc_q;
        small_val = op_is_big ? acc_q : op_q;
        exp_diff  = big_val[W-2:MANTISSA_WIDTH] - small_val[W-2:MANTISSA_WIDTH];
        if (32'(exp_diff) > SIG_W - 1) begin
            small_aligned = '0;
        end else begin
            small_aligned = significand(small_val) >> exp_diff;
        end
    end

    assign sum_d = eff_sub_q ? ({1'b0, big_sig_q} - {1'b0, small_sig_q})
                             : ({1'b0, big_sig_q} + {1'b0, small_sig_q});

    logic [CNT_W-1:0] lz;
    logic [SIG_W-1:0] norm_sig;
    logic [XE_W-1:0]  norm_exp;
    logic             exp_under, exp_over;
    logic [W-1:0]     norm_result;
    logic             unused_guard;

    leading_zero_count #(
        .WIDTH      (SIG_W),
        .COUNT_WIDTH(CNT_W)
    ) u_lzc (
        .value(sum_q[SIG_W-1:0]),
        .count(lz)
    );

    always_comb begin
        if (sum_q[SIG_W]) begin
            norm_sig = sum_q[SIG_W:1];
            norm_exp = {2'b00, big_exp_q} + XE_W'(1);
        end else begin
            norm_sig = sum_q[SIG_W-1:0] << lz;
            norm_exp = {2'b00, big_exp_q} - XE_W'(lz);
        end
        exp_under   = norm_exp[XE_W-1] || (norm_exp == '0);
        exp_over    = !norm_exp[XE_W-1] && (norm_exp >= EXP_SAT);
        norm_result = {big_sign_q, norm_exp[EXPONENT_WIDTH-1:0],
                       norm_sig[SIG_W-2 -: MANTISSA_WIDTH]};
        if (sum_q == '0 || exp_under) begin
            norm_result = '0;
        end else if (exp_over) begin
            norm_result = sat_value(big_sign_q);
        end
    end

    assign unused_guard = ^{norm_sig[GUARD_W-1:0], norm_exp[XE_W-2:EXPONENT_WIDTH]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = last_q ? S_EMIT : S_IDLE;
            S_EMIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            elem_out_q  <= '0;
            last_q      <= 1'b0;
            big_sign_q  <= 1'b0;
            eff_sub_q   <= 1'b0;
            big_exp_q   <= '0;
            big_sig_q   <= '0;
            small_sig_q <= '0;
            sum_q       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op_clean;
                        last_q <= in_last;
                    end
                end
                S_ALIGN: begin
                    big_sign_q  <= big_val[W-1];
                    eff_sub_q   <= big_val[W-1] ^ small_val[W-1];
                    big_exp_q   <= big_val[W-2:MANTISSA_WIDTH];
                    big_sig_q   <= significand(big_val);
                    small_sig_q <= small_aligned;
                end
                S_ADD: sum_q <= sum_d;
                S_NORM: begin
                    acc_q <= norm_result;
                    // Load the output here so it is already stable during the EMIT strobe.
                    if (last_q) elem_out_q <= norm_result;
                end
                S_EMIT: acc_q <= '0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_EMIT);
    assign elem_out  = elem_out_q;

endmodule

// File: tb/tb_element_accumulate_f.sv
// Self-checking bench for element_accumulate_f: directed cases plus random
// bundles compared against an integer-arithmetic reference model.
module tb_element_accumulate_f;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [31:0] elem_in;
    logic        out_valid;
    logic [31:0] elem_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] acc_model;
    logic [31:0] g;

    always #5 clk = ~clk;

    element_accumulate_f #(
        .EXPONENT_WIDTH(8),
        .MANTISSA_WIDTH(23)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .elem_in  (elem_in),
        .out_valid(out_valid),
        .elem_out (elem_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sanitize(input logic [31:0] v);
        if (v[30:23] == 8'h00) return 32'h0;
        if (v[30:23] == 8'hFF) return {v[31], 31'h7F7FFFFF};
        return v;
    endfunction

    // Value = sig * 2^(exp-bias); carry three guard bits below the larger operand's LSB.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        longint      sx, sy, r;
        int          ex, ey, e, d;
        x = sanitize(a);
        y = sanitize(b);
        if (y[30:0] > x[30:0]) begin
            t = x; x = y; y = t;
        end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sx = (ex == 0) ? 64'sd0 : longint'({1'b1, x[22:0]}) * 8;
        sy = (ey == 0) ? 64'sd0 : longint'({1'b1, y[22:0]}) * 8;
        d  = ex - ey;
        if (d > 26) sy = 0;
        else        sy = sy / (longint'(1) << d);
        r = (x[31] == y[31]) ? sx + sy : sx - sy;
        if (r == 0) return 32'h0;
        e = ex;
        while (r >= (longint'(1) << 27)) begin r = r / 2; e++; end
        while (r <  (longint'(1) << 26)) begin r = r * 2; e--; end
        if (e <= 0)   return 32'h0;
        if (e >= 255) return {x[31], 31'h7F7FFFFF};
        return {x[31], e[7:0], r[25:3]};
    endfunction

    function automatic logic [31:0] rand_elem();
        int         sel;
        logic [7:0] ex;
        sel = int'($urandom_range(0, 19));
        case (sel)
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            2:       ex = 8'($urandom_range(240, 254));
            3:       ex = 8'($urandom_range(1, 8));
            default: ex = 8'($urandom_range(110, 140));
        endcase
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    // Offer one element, then check the busy window, the strobe timing and the sum.
    task automatic send(input logic [31:0] e, input logic last, output logic [31:0] got);
        int wait_cnt = 0;
        got = 32'h0;
        @(negedge clk);
        in_valid = 1'b1;
        elem_in  = e;
        in_last  = last;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        acc_model = model_add(acc_model, e);
        // Garbage offered while busy must be ignored.
        elem_in = $urandom;
        in_last = 1'($urandom);
        for (int k = 1; k <= 3; k++) begin
            check("busy", 32'({in_ready, out_valid}), 32'd0);
            if (k == 3) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
        end
        if (last) begin
            check("emit_strobe", 32'({in_ready, out_valid}), 32'd1);
            check("sum", elem_out, acc_model);
            got       = elem_out;
            acc_model = 32'h0;
            @(negedge clk);
            check("post_emit", 32'({in_ready, out_valid}), 32'd2);
            check("hold_out", elem_out, got);
        end else begin
            check("ready_again", 32'({in_ready, out_valid}), 32'd2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        elem_in   = 32'h0;
        acc_model = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({in_ready, out_valid}), 32'd2);
        check("reset_out", elem_out, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ctrl", 32'({in_ready, out_valid}), 32'd2);

        send(32'h3F800000, 1'b0, g);
        send(32'h3F800000, 1'b1, g);
        check("one_plus_one", g, 32'h40000000);

        send(32'h3FC00000, 1'b0, g);
        send(32'h3E800000, 1'b0, g);
        send(32'hBF400000, 1'b1, g);
        check("mixed_signs", g, 32'h3F800000);

        send(32'h3F800000, 1'b0, g);
        send(32'hBF800000, 1'b1, g);
        check("cancel", g, 32'h00000000);
        send(32'h40400000, 1'b1, g);
        check("acc_cleared", g, 32'h40400000);

        send(32'h4E800000, 1'b0, g);
        send(32'h3F800000, 1'b1, g);
        check("exp_gap", g, 32'h4E800000);

        send(32'h7F7FFFFF, 1'b0, g);
        send(32'h7F7FFFFF, 1'b1, g);
        check("overflow_sat", g, 32'h7F7FFFFF);
        send(32'h7F800000, 1'b1, g);
        check("inf_clamp", g, 32'h7F7FFFFF);
        send(32'h00000001, 1'b1, g);
        check("denorm_flush", g, 32'h00000000);

        // Reset while the last element sits in ADD.
        @(negedge clk);
        in_valid = 1'b1;
        elem_in  = 32'h3F800000;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midadd_reset_ctrl", 32'({in_ready, out_valid}), 32'd2);
        check("midadd_reset_out", elem_out, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("reset_no_strobe", 32'(out_valid), 32'd0);
        end
        reset_n   = 1'b1;
        acc_model = 32'h0;
        @(negedge clk);
        check("release_no_strobe", 32'(out_valid), 32'd0);
        send(32'h40000000, 1'b1, g);
        check("after_reset", g, 32'h40000000);

        for (int b = 0; b < 60; b++) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                send(rand_elem(), 1'(i == len - 1), g);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/element_accumulate_f.md
# element_accumulate_f

Multi-cycle floating-point accumulator for the bundling path. It sums a stream of sign/exponent/mantissa hypervector elements (one dimension, across K bound vectors) into a running total. When the last element of a bundle is absorbed, it emits the total for one cycle to the downstream element-addition-cut (bipolar) stage, which consumes `elem_out` when `out_valid` is high. Each element takes a fixed four-cycle add; there is no downstream backpressure.

## Interface
- EXPONENT_WIDTH, 8: exponent field width (biased, IEEE-754 style).
- MANTISSA_WIDTH, 23: stored fraction width (hidden bit implied).
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  `elem_in`/`in_last` valid this cycle.
- in_ready  output  1  block can accept an element (high only in IDLE).
- in_last  input  1  element is the final one of the current bundle.
- elem_in  input  EXPONENT_WIDTH+MANTISSA_WIDTH+1  {sign, exponent, mantissa}.
- out_valid  output  1  one-cycle strobe: `elem_out` holds a completed bundle sum.
- elem_out  output  EXPONENT_WIDTH+MANTISSA_WIDTH+1  {sign, exponent, mantissa} of the sum.

## Operation
- States: IDLE, ALIGN, ADD, NORM, EMIT.
- IDLE: in_ready=1. On in_valid, latch the operand and in_last, then go to ALIGN. Otherwise stay.
- ALIGN: compare the accumulator and operand exponents. Right-shift the smaller significand (hidden bit + mantissa + 3 guard bits) by the difference.
  - If the difference exceeds MANTISSA_WIDTH+3, the smaller operand becomes 0.
- ADD: signed-magnitude add or subtract of the aligned significands, with one carry bit. Result sign is the sign of the larger magnitude.
- NORM: leading-zero count, then shift. Adjust the exponent (+1 on carry, −lzc otherwise), truncate the guard bits (round toward zero), and write the accumulator.
  - Go to EMIT if the latched last flag is set, else to IDLE.
- EMIT: out_valid=1. elem_out ← accumulator, accumulator ← +0, then go to IDLE.
- Arithmetic rules:
  - Input exponent all-zeros: operand treated as +0 (denormals flushed).
  - Input exponent all-ones: operand treated as max finite of that sign (exp=2^E−2, mantissa all ones).
  - Exact cancellation: result +0.
  - Exponent underflow (≤0): result +0.
  - Exponent overflow (≥2^E−1): saturate to max finite with the result sign.
- Accumulator starts at +0 after reset and after every EMIT.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, elem_out=0, accumulator=+0, state=IDLE.
- Accept at edge n: ALIGN during n+1, ADD during n+2, NORM during n+3.
- For a last element, EMIT is during n+4, so out_valid is high in cycle n+4 only. in_ready returns high in n+5.
- For a non-last element, IDLE is in n+4, so in_ready is high in n+4.
- Throughput: 1 element / 4 cycles mid-bundle; 5 cycles for the last element.
- in_valid while in_ready=0 is ignored. Upstream holds data until it sees in_ready.
- elem_out is registered and holds the last emitted sum until the next EMIT.
- reset_n low at any time, including mid-add, forces the reset values immediately. The partial sum is discarded and out_valid is not raised.
- A single-element bundle (in_last on the first element) emits that element, normalized per the rules above.

## Structure
- Shared package `hdc_float_pkg`:
  - state enum `acc_state_t`
  - field-width localparams (exp/mant/guard widths)
  - function `max_finite(sign)`
  - constant `FP_ZERO`
- Sub-module `leading_zero_count` (parameterized width, combinational), used in NORM.
- Top module `element_accumulate_f` holds the FSM, operand/accumulator registers and alignment shifter.

## Test plan
- 0x3F800000 (1.0) then 0x3F800000 with in_last: out_valid exactly 4 cycles after the last accept, elem_out=0x40000000 (2.0).
- 0x3FC00000 (1.5), 0x3E800000 (0.25), 0xBF400000 (−0.75, last): elem_out=0x3F800000. in_ready is low for exactly 3 cycles after each accept.
- 0x3F800000, 0xBF800000 (last): elem_out=0x00000000 (cancellation gives +0). The next bundle, 0x40400000 (last), gives 0x40400000, confirming the accumulator was cleared.
- Exponent gap: 0x4E800000 (2^30) + 0x3F800000 (last): elem_out=0x4E800000.
- Saturation: 0x7F7FFFFF + 0x7F7FFFFF (last) → 0x7F7FFFFF. 0x7F800000 alone (last) → 0x7F7FFFFF. 0x00000001 alone (last) → 0x00000000.
- Assert reset_n during the ADD state of the last element: out_valid stays 0 and elem_out=0. After release, 0x40000000 (last) → elem_out=0x40000000.
